wb_arbiter: RTL

Write-back arbiter for the 16 × 16-bit register file write port. Two producers, the ALU result path (A) and the memory load path (M), each hand over writes through a valid/ready handshake into a one-entry holding buffer. A round-robin, age-aware arbiter drains the buffers onto registered `RegWre`/`WriteReg`/`WriteData` outputs that drive the register file directly. A per-register pending vector tells decode which registers have writes still in flight.

---
 rtl/wb_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Round-robin, age-aware arbiter that merges the ALU and load write-backs onto the register file port.
// One cycle from accept to RegWre; a path's ready drops only while its buffer is full and not granted.
module wb_arbiter #(
    parameter int NREG = 16,
    parameter int DW   = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_reg,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            m_valid,
    input  logic [AW-1:0]   m_reg,
    input  logic [DW-1:0]   m_data,
    output logic            m_ready,
    output logic            RegWre,
    output logic [AW-1:0]   WriteReg,
    output logic [DW-1:0]   WriteData,
    output logic [NREG-1:0] pending
);

    logic            r_a_vld, r_m_vld;
    logic [AW-1:0]   r_a_reg, r_m_reg;
    logic [DW-1:0]   r_a_dat, r_m_dat;
    logic            r_a_old, r_m_old;
    logic            r_last_m;

    logic            w_grant_a, w_grant_m;
    logic            w_a_load, w_m_load;
    logic            w_a_hold, w_m_hold;
    logic            w_a_old_nxt, w_m_old_nxt;
    logic [NREG-1:0] w_pending;

    // Grant looks only at buffer state so ready never depends on valid.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_m = 1'b0;
        if (r_a_vld && r_m_vld) begin
            if (r_a_reg == r_m_reg) begin
                if (r_a_old && !r_m_old) w_grant_a = 1'b1;
                else                     w_grant_m = 1'b1;
            end else if (r_last_m) begin
                w_grant_a = 1'b1;
            end else begin
                w_grant_m = 1'b1;
            end
        end else if (r_a_vld) begin
            w_grant_a = 1'b1;
        end else if (r_m_vld) begin
            w_grant_m = 1'b1;
        end
    end

    assign a_ready  = !r_a_vld || w_grant_a;
    assign m_ready  = !r_m_vld || w_grant_m;
    assign w_a_load = a_valid && a_ready && (a_reg != '0);
    assign w_m_load = m_valid && m_ready && (m_reg != '0);
    assign w_a_hold = r_a_vld && !w_grant_a;
    assign w_m_hold = r_m_vld && !w_grant_m;

    // A newcomer is younger than an entry left waiting; loads on the same edge tie and M wins.
    always_comb begin
        w_a_old_nxt = r_a_old;
        w_m_old_nxt = r_m_old;
        if (w_a_load)                 w_a_old_nxt = !w_m_hold;
        else if (w_m_load && w_a_hold) w_a_old_nxt = 1'b1;
        if (w_m_load)                 w_m_old_nxt = !w_a_hold;
        else if (w_a_load && w_m_hold) w_m_old_nxt = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_a_vld   <= 1'b0;
            r_a_reg   <= '0;
            r_a_dat   <= '0;
            r_a_old   <= 1'b0;
            r_m_vld   <= 1'b0;
            r_m_reg   <= '0;
            r_m_dat   <= '0;
            r_m_old   <= 1'b0;
            r_last_m  <= 1'b1;
            RegWre    <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            r_a_old <= w_a_old_nxt;
            r_m_old <= w_m_old_nxt;
            if (w_a_load) begin
                r_a_vld <= 1'b1;
                r_a_reg <= a_reg;
                r_a_dat <= a_data;
            end else if (w_grant_a) begin
                r_a_vld <= 1'b0;
            end
            if (w_m_load) begin
                r_m_vld <= 1'b1;
                r_m_reg <= m_reg;
                r_m_dat <= m_data;
            end else if (w_grant_m) begin
                r_m_vld <= 1'b0;
            end
            if (r_a_vld && r_m_vld) r_last_m <= w_grant_m;
            RegWre <= w_grant_a || w_grant_m;
            if (w_grant_a) begin
                WriteReg  <= r_a_reg;
                WriteData <= r_a_dat;
            end else if (w_grant_m) begin
                WriteReg  <= r_m_reg;
                WriteData <= r_m_dat;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        if (r_a_vld) w_pending[r_a_reg]  = 1'b1;
        if (r_m_vld) w_pending[r_m_reg]  = 1'b1;
        if (RegWre)  w_pending[WriteReg] = 1'b1;
    end

    assign pending = w_pending;

endmodule
